// File: rtl/regfile_dump_ctrl_pkg.sv
// Shared constants and state encoding for the register-file dump controller.
package regfile_dump_ctrl_pkg;

    localparam int unsigned BYTE_W = 8;

    // Bytes streamed by one dump at the default 32 x 32-bit register file.
    localparam int unsigned DUMP_BYTES = 32 * (32 / BYTE_W);

    typedef enum logic [2:0] {
        DUMP_IDLE,
        DUMP_SELECT,
        DUMP_LOAD,
        DUMP_SEND,
        DUMP_DONE
    } dump_state_e;

    function automatic int unsigned dump_byte_count(input int unsigned length,
                                                    input int unsigned width);
        return length * (width / BYTE_W);
    endfunction

endpackage

// File: rtl/regfile_dump_ctrl_if.sv
// Byte stream link from the dump controller to the UART transmitter.
interface regfile_dump_ctrl_if;
    import regfile_dump_ctrl_pkg::*;

    logic [BYTE_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/regfile_dump_ctrl_serializer.sv
// Word-to-byte serializer: loads a register word and shifts it out MSB byte first.
module regfile_dump_ctrl_serializer
    import regfile_dump_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [WIDTH-1:0]  word,
    output logic [BYTE_W-1:0] byte_out,
    output logic              last
);

    localparam int unsigned BYTES = WIDTH / BYTE_W;
    localparam int unsigned CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Load takes priority; a shift moves the next byte into the top slot.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (load) begin
            shift_d = word;
            cnt_d   = '0;
        end else if (shift) begin
            shift_d = shift_q << BYTE_W;
            cnt_d   = cnt_q + CW'(1);
        end
    end

    // Shift register and byte counter state.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign byte_out = shift_q[WIDTH-1 -: BYTE_W];
    assign last     = (cnt_q == CW'(BYTES - 1));

endmodule

// File: rtl/regfile_dump_ctrl.sv
// Freezes the MIPS pipeline and streams every register out as bytes, MSB first.
module regfile_dump_ctrl
    import regfile_dump_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned LENGTH = 32,
    parameter int unsigned NB     = $clog2(LENGTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dump_start,
    input  logic                 mips_enable_in,
    output logic                 mips_enable_out,
    input  logic [NB-1:0]        dp_read_reg_1,
    output logic [NB-1:0]        rf_read_reg_1,
    input  logic [WIDTH-1:0]     rf_read_data_1,
    output logic                 busy,
    output logic                 done,
    regfile_dump_ctrl_if.master  tx
);

    dump_state_e   state_q, state_d;
    logic [NB-1:0] idx_q, idx_d;
    logic          ser_load;
    logic          ser_last;
    logic          accept;
    logic [BYTE_W-1:0] ser_byte;

    assign accept = (state_q == DUMP_SEND) && tx.tx_ready;

    regfile_dump_ctrl_serializer #(
        .WIDTH (WIDTH)
    ) u_serializer (
        .clk      (clk),
        .reset    (reset),
        .load     (ser_load),
        .shift    (accept),
        .word     (rf_read_data_1),
        .byte_out (ser_byte),
        .last     (ser_last)
    );

    // Next-state logic: walk registers 0..LENGTH-1, one SELECT/LOAD/SEND group each.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ser_load = 1'b0;
        unique case (state_q)
            DUMP_IDLE: begin
                if (dump_start) begin
                    state_d = DUMP_SELECT;
                    idx_d   = '0;
                end
            end
            DUMP_SELECT: state_d = DUMP_LOAD;
            DUMP_LOAD: begin
                ser_load = 1'b1;
                state_d  = DUMP_SEND;
            end
            DUMP_SEND: begin
                if (accept && ser_last) begin
                    if (idx_q == NB'(LENGTH - 1)) begin
                        state_d = DUMP_DONE;
                    end else begin
                        idx_d   = idx_q + NB'(1);
                        state_d = DUMP_SELECT;
                    end
                end
            end
            DUMP_DONE: state_d = DUMP_IDLE;
            default:   state_d = DUMP_IDLE;
        endcase
    end

    // State and register index.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DUMP_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign busy            = (state_q != DUMP_IDLE);
    assign done            = (state_q == DUMP_DONE);
    assign tx.tx_valid     = (state_q == DUMP_SEND);
    assign tx.tx_data      = ser_byte;
    assign rf_read_reg_1   = busy ? idx_q : dp_read_reg_1;
    // Gating the pipeline clock enable keeps the snapshot free of writes.
    assign mips_enable_out = mips_enable_in & ~busy;

endmodule
